bram_1rw_be_init: RTL and testbench

//  Parametrised single-port block RAM: byte-granular writes, selectable read-during-write mode,

---
 rtl/bram_1rw_be_init.sv | 137 +++++++++++++
 tb/tb_bram_1rw_be_init.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_1rw_be_init.sv
// Single-port block RAM with byte-lane writes and selectable read-during-write.
// A hardware sweep fills every word with INIT_VAL after reset before requests are accepted.
module bram_1rw_be_init #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int BYTE_WIDTH = 8,
  parameter int MEMSIZE    = 1024,
  parameter int OUT_REG    = 0,
  parameter int WRITE_MODE = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                             clka,
  input  logic                             rst_n,
  input  logic                             ena,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]            addra,
  input  logic [DATA_WIDTH-1:0]            dina,
  output logic [DATA_WIDTH-1:0]            douta,
  output logic                             dvalid,
  output logic                             init_done
);

  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int AI = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [ADDR_WIDTH:0] MSZ =
    (ADDR_WIDTH+1)'(MEMSIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(MEMSIZE - 1);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   ram [MEMSIZE];

  logic                    acc;
  logic                    wr;
  logic                    inr;
  logic                    fire;
  logic [AI-1:0]           idx;
  logic [DATA_WIDTH-1:0]   old_w;
  logic [DATA_WIDTH-1:0]   new_w;
  logic [DATA_WIDTH-1:0]   rsp;

  logic                    v1;
  logic [DATA_WIDTH-1:0]   d1;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= S_READY;
            init_done <= 1'b1;
          end
        end
        S_READY: begin
          state <= S_READY;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

  assign acc = init_done & ena;
  assign wr  = |wea;
  assign inr = {1'b0, addra} < MSZ;
  assign idx = addra[AI-1:0];

  // Out-of-range words read as zero and their writes are dropped
  always_comb begin
    old_w = '0;
    if (inr) old_w = ram[idx];
    new_w = old_w;
    for (int b = 0; b < NBYTES; b++) begin
      if (wea[b])
        new_w[b*BYTE_WIDTH +: BYTE_WIDTH] =
          dina[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
    rsp = old_w;
    if (wr && WRITE_MODE == 2)
      rsp = inr ? new_w : '0;
  end

  assign fire = acc & (~wr | (WRITE_MODE != 0));

  always_ff @(posedge clka) begin
    if (!init_done)
      ram[cnt[AI-1:0]] <= INIT_VAL;
    else if (acc && wr && inr)
      ram[idx] <= new_w;
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= fire;
      if (fire) d1 <= rsp;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  v2;
      logic [DATA_WIDTH-1:0] d2;

      always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end

      assign douta  = d2;
      assign dvalid = v2;
    end else begin : g_noreg
      assign douta  = d1;
      assign dvalid = v1;
    end
  endgenerate

endmodule

// File: tb/tb_bram_1rw_be_init.sv
// Bench for bram_1rw_be_init: three configurations share one stimulus stream
// and are checked every cycle against a word-array model with timed result slots.
module tb_bram_1rw_be_init;

  localparam logic [63:0] IV0 = 64'h0000_0000_0000_A5A5;
  localparam logic [63:0] IV1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] IV2 = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  wea;
  logic [3:0]  addra;
  logic [63:0] dina;

  logic [63:0] dq0, dq1, dq2;
  logic        dv0, dv1, dv2;
  logic        id0, id1, id2;

  logic [63:0] dq [3];
  logic        dv [3];
  logic        id [3];

  assign dq[0] = dq0;
  assign dq[1] = dq1;
  assign dq[2] = dq2;
  assign dv[0] = dv0;
  assign dv[1] = dv1;
  assign dv[2] = dv2;
  assign id[0] = id0;
  assign id[1] = id1;
  assign id[2] = id2;

  always #5 clk = ~clk;

  bram_1rw_be_init #(
    .ADDR_WIDTH(4), .DATA_WIDTH(64), .BYTE_WIDTH(8),
    .MEMSIZE(16), .OUT_REG(0), .WRITE_MODE(0), .INIT_VAL(IV0)
  ) u0 (
    .clka(clk), .rst_n(rst_n), .ena(ena), .wea(wea),
    .addra(addra), .dina(dina), .douta(dq0),
    .dvalid(dv0), .init_done(id0)
  );

  bram_1rw_be_init #(
    .ADDR_WIDTH(4), .DATA_WIDTH(64), .BYTE_WIDTH(8),
    .MEMSIZE(16), .OUT_REG(1), .WRITE_MODE(1), .INIT_VAL(IV1)
  ) u1 (
    .clka(clk), .rst_n(rst_n), .ena(ena), .wea(wea),
    .addra(addra), .dina(dina), .douta(dq1),
    .dvalid(dv1), .init_done(id1)
  );

  bram_1rw_be_init #(
    .ADDR_WIDTH(4), .DATA_WIDTH(64), .BYTE_WIDTH(8),
    .MEMSIZE(12), .OUT_REG(0), .WRITE_MODE(2), .INIT_VAL(IV2)
  ) u2 (
    .clka(clk), .rst_n(rst_n), .ena(ena), .wea(wea),
    .addra(addra), .dina(dina), .douta(dq2),
    .dvalid(dv2), .init_done(id2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [63:0] mm   [3][16];
  int          scnt [3];
  bit          rdy  [3];
  bit          ev   [3][4];
  logic [63:0] ed   [3][4];
  logic [63:0] last [3];

  function automatic int ms(input int i);
    return (i == 2) ? 12 : 16;
  endfunction

  function automatic int lat(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int wm(input int i);
    return i;
  endfunction

  function automatic logic [63:0] iv(input int i);
    case (i)
      0:       return IV0;
      1:       return IV1;
      default: return IV2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic push(input int i, input int due,
                      input logic [63:0] d);
    ev[i][due % 4] = 1'b1;
    ed[i][due % 4] = d;
  endtask

  task automatic step(input int i);
    logic [63:0] o;
    logic [63:0] n;
    bit          inr;
    int          due;
    if (!rdy[i]) begin
      mm[i][scnt[i]] = iv(i);
      scnt[i]++;
      if (scnt[i] == ms(i)) rdy[i] = 1'b1;
    end else if (ena) begin
      inr = (int'(addra) < ms(i));
      o = inr ? mm[i][addra] : 64'h0;
      n = o;
      for (int b = 0; b < 8; b++)
        if (wea[b]) n[b*8 +: 8] = dina[b*8 +: 8];
      due = cyc + lat(i) - 1;
      if (wea == 8'h00) begin
        push(i, due, o);
      end else begin
        if (inr) mm[i][addra] = n;
        if (wm(i) == 1) push(i, due, o);
        if (wm(i) == 2) push(i, due, inr ? n : 64'h0);
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
      for (int i = 0; i < 3; i++) step(i);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        rdy[i]  = 1'b0;
        scnt[i] = 0;
        last[i] = 64'h0;
        for (int s = 0; s < 4; s++) ev[i][s] = 1'b0;
        chk($sformatf("rst_dout%0d", i), dq[i], 64'h0);
        chk($sformatf("rst_flags%0d", i),
            {62'b0, dv[i], id[i]}, 64'h0);
      end else begin
        bit edv;
        edv = ev[i][cyc % 4];
        if (edv) begin
          last[i] = ed[i][cyc % 4];
          ev[i][cyc % 4] = 1'b0;
        end
        chk($sformatf("dout%0d@%0d", i, cyc), dq[i], last[i]);
        chk($sformatf("flags%0d@%0d", i, cyc),
            {62'b0, dv[i], id[i]},
            {62'b0, edv, rdy[i]});
      end
    end
  end

  task automatic req(input bit e, input logic [7:0] w,
                     input logic [3:0] a, input logic [63:0] d);
    ena   = e;
    wea   = w;
    addra = a;
    dina  = d;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    req(1'b0, 8'h00, 4'h0, 64'h0);
  endtask

  task automatic noise();
    req(1'($urandom), 8'($urandom), 4'($urandom),
        {$urandom, $urandom});
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) req(1'b1, 8'h00, 4'(a), 64'h0);
    idle();
    idle();
  endtask

  task automatic sweep_check(input string nm);
    for (int k = 0; k < 15; k++) noise();
    chk({nm, "_lo"}, {63'b0, id0}, 64'h0);
    noise();
    chk({nm, "_hi"}, {63'b0, id0}, 64'h1);
    chk({nm, "_hi2"}, {63'b0, id2}, 64'h1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    ena   = 1'b0;
    wea   = 8'h00;
    addra = 4'h0;
    dina  = 64'h0;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    sweep_check("init");

    for (int a = 0; a < 16; a++) begin
      req(1'b1, 8'h00, 4'(a), 64'h0);
      if (a == 5) chk("rd_a5a5", dq0, 64'h0000_0000_0000_A5A5);
    end
    idle();

    req(1'b1, 8'h0F, 4'd3, 64'h1111_2222_3333_4444);
    req(1'b1, 8'h00, 4'd3, 64'h0);
    idle();
    chk("be_merge", dq1, 64'hFFFF_FFFF_3333_4444);
    chk("be_dv", {63'b0, dv1}, 64'h1);
    chk("mdl_be", mm[1][3], 64'hFFFF_FFFF_3333_4444);

    req(1'b1, 8'hFF, 4'd5, 64'h1234);
    req(1'b1, 8'hFF, 4'd5, 64'hBEEF);
    chk("wm0_none", {63'b0, dv0}, 64'h0);
    chk("wm2_new", dq2, 64'hBEEF);
    req(1'b1, 8'h00, 4'd5, 64'h0);
    chk("wm1_old", dq1, 64'h1234);
    chk("raw_wm0", dq0, 64'hBEEF);
    idle();
    chk("raw_wm1", dq1, 64'hBEEF);

    req(1'b1, 8'hFF, 4'd13, 64'hDEAD_BEEF_CAFE_F00D);
    chk("oor_wr2", dq2, 64'h0);
    req(1'b1, 8'h00, 4'd13, 64'h0);
    chk("oor_rd", dq2, 64'h0);
    chk("oor_dv", {63'b0, dv2}, 64'h1);
    chk("mdl_oor", mm[2][11], IV2);

    idle();
    idle();
    n = 0;
    for (int a = 0; a < 8; a++) begin
      req(1'b1, 8'h00, 4'(a), 64'h0);
      if (a == 0) chk("stream_lat", {63'b0, dv1}, 64'h0);
      n += int'(dv1);
    end
    idle();
    n += int'(dv1);
    idle();
    n += int'(dv1);
    chk("stream_cnt", 64'(n), 64'd8);

    read_all();

    req(1'b1, 8'h00, 4'd2, 64'h0);
    rst_n = 1'b0;
    idle();
    idle();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) noise();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    sweep_check("resweep");
    read_all();

    for (int k = 0; k < 3000; k++) begin
      req(1'($urandom % 4 != 0),
          ($urandom % 2) ? 8'h00 : 8'($urandom),
          4'($urandom), {$urandom, $urandom});
    end
    read_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
